// File: rtl/aes_shift_rows_stage.sv
// Registered ShiftRows/InvShiftRows stage with a 2-entry skid buffer; optional macro AES_SHIFT_ROWS_STAGE_COUNT_EN adds Block_count.
// Latency: 1 cycle from input transfer to Out_*; sustains 1 block/cycle.
// Backpressure: In_ready/Out_valid are registered from occupancy, so there is no combinational Out_ready->In_ready path.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

module aes_shift_rows_stage #(
  parameter int BLOCK_SIZE = `AES_BLOCK_SIZE
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  In_valid,
  output logic                  In_ready,
  input  logic                  In_encrypt,
  input  logic [BLOCK_SIZE-1:0] In_block,
  output logic                  Out_valid,
  input  logic                  Out_ready,
  output logic                  Out_encrypt,
  output logic [BLOCK_SIZE-1:0] Out_block
`ifdef AES_SHIFT_ROWS_STAGE_COUNT_EN
  ,
  output logic [31:0]           Block_count
`endif
);

  localparam int DEPTH = 2;
  localparam logic [1:0] CNT_FULL = 2'(DEPTH);

  logic [BLOCK_SIZE-1:0] enc_blk;
  logic [BLOCK_SIZE-1:0] dec_blk;
  logic [BLOCK_SIZE-1:0] perm_blk;

  logic [1:0]            cnt;
  logic [1:0]            cnt_nxt;
  logic [BLOCK_SIZE-1:0] head_blk;
  logic                  head_enc;
  logic [BLOCK_SIZE-1:0] skid_blk;
  logic                  skid_enc;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic push;
  logic pop;
  logic load_head;
  logic head_from_skid;
  logic load_skid;

  // Byte k = row (k%4), column (k/4); row r rotates left by r for encrypt, right for decrypt.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign enc_blk[8*(r+4*c) +: 8] = In_block[8*(r+4*((c+r)%4)) +: 8];
      assign dec_blk[8*(r+4*c) +: 8] = In_block[8*(r+4*((c-r+4)%4)) +: 8];
    end
  end

  assign perm_blk = In_encrypt ? enc_blk : dec_blk;

  assign push = In_valid & in_ready_q;
  assign pop  = out_valid_q & Out_ready;

  always_comb begin
    cnt_nxt        = cnt;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (cnt)
      2'd0: begin
        if (push) begin
          load_head = 1'b1;
          cnt_nxt   = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          cnt_nxt   = 2'd2;
        end else if (pop) begin
          cnt_nxt   = 2'd0;
        end
      end
      2'd2: begin
        // In_ready is low at full, so only a pop can happen here.
        if (pop) begin
          load_head      = 1'b1;
          head_from_skid = 1'b1;
          cnt_nxt        = 2'd1;
        end
      end
      default: cnt_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt         <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      head_blk    <= '0;
      head_enc    <= 1'b0;
      skid_blk    <= '0;
      skid_enc    <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      in_ready_q  <= (cnt_nxt != CNT_FULL);
      out_valid_q <= (cnt_nxt != 2'd0);
      if (load_head) begin
        head_blk <= head_from_skid ? skid_blk : perm_blk;
        head_enc <= head_from_skid ? skid_enc : In_encrypt;
      end
      if (load_skid) begin
        skid_blk <= perm_blk;
        skid_enc <= In_encrypt;
      end
    end
  end

  assign In_ready    = in_ready_q;
  assign Out_valid   = out_valid_q;
  assign Out_block   = head_blk;
  assign Out_encrypt = head_enc;

`ifdef AES_SHIFT_ROWS_STAGE_COUNT_EN
  logic [31:0] block_count_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      block_count_q <= 32'd0;
    end else if (pop) begin
      block_count_q <= block_count_q + 32'd1;
    end
  end

  assign Block_count = block_count_q;
`endif

endmodule

// File: tb/tb_aes_shift_rows_stage.sv
// Bench for aes_shift_rows_stage: fixed vectors, stall/stream/reset sequences, random traffic vs a queue model.
module tb_aes_shift_rows_stage;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         In_valid = 1'b0;
  logic         In_ready;
  logic         In_encrypt = 1'b0;
  logic [127:0] In_block = '0;
  logic         Out_valid;
  logic         Out_ready = 1'b0;
  logic         Out_encrypt;
  logic [127:0] Out_block;
`ifdef AES_SHIFT_ROWS_STAGE_COUNT_EN
  logic [31:0]  Block_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  aes_shift_rows_stage dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .In_valid   (In_valid),
    .In_ready   (In_ready),
    .In_encrypt (In_encrypt),
    .In_block   (In_block),
    .Out_valid  (Out_valid),
    .Out_ready  (Out_ready),
    .Out_encrypt(Out_encrypt),
    .Out_block  (Out_block)
`ifdef AES_SHIFT_ROWS_STAGE_COUNT_EN
    ,
    .Block_count(Block_count)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference permutation: each row of the 4x4 byte matrix is rotated as a list.
  function automatic logic [127:0] ref_perm(input logic [127:0] x, input logic enc);
    logic [7:0] m [4][4];
    logic [7:0] row [4];
    logic [127:0] y;
    for (int k = 0; k < 16; k++) m[k%4][k/4] = x[8*k +: 8];
    y = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) row[c] = enc ? m[r][(c+r)%4] : m[r][(c+4-r)%4];
      for (int c = 0; c < 4; c++) y[8*(r+4*c) +: 8] = row[c];
    end
    return y;
  endfunction

  // Behavioural model: a bounded FIFO of already-permuted blocks.
  typedef struct packed {
    logic [127:0] blk;
    logic         enc;
  } item_t;

  item_t        mq[$];
  bit           m_started = 0;
  logic [127:0] m_last_blk = '0;
  logic         m_last_enc = 1'b0;
  logic [31:0]  m_pops = '0;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mq.delete();
      m_started  = 0;
      m_last_blk = '0;
      m_last_enc = 1'b0;
      m_pops     = '0;
    end else begin
      bit    acc;
      bit    rel;
      item_t it;
      acc = In_valid && m_started && (mq.size() < 2);
      rel = Out_ready && (mq.size() != 0);
      if (rel) begin
        void'(mq.pop_front());
        m_pops = m_pops + 32'd1;
      end
      if (acc) begin
        it.blk = ref_perm(In_block, In_encrypt);
        it.enc = In_encrypt;
        mq.push_back(it);
      end
      m_started = 1;
      if (mq.size() != 0) begin
        m_last_blk = mq[0].blk;
        m_last_enc = mq[0].enc;
      end
    end
  end

  always @(negedge Clk) begin
    chk("model_out_valid", 128'(Out_valid), 128'(mq.size() != 0));
    chk("model_in_ready", 128'(In_ready), 128'(m_started && (mq.size() < 2)));
    chk("model_out_block", Out_block, m_last_blk);
    chk("model_out_encrypt", 128'(Out_encrypt), 128'(m_last_enc));
`ifdef AES_SHIFT_ROWS_STAGE_COUNT_EN
    chk("model_block_count", 128'(Block_count), 128'(m_pops));
`endif
  end

  typedef struct {
    logic [127:0] blk;
    logic         enc;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [127:0] a, b, c, x, y;
    logic [127:0] sblk [16];
    logic [127:0] held;

    tbl[0] = '{128'h30_52_41_1e_e5_5d_b4_b8_f1_98_bf_e0_ae_11_27_d4, 1'b1,
               128'he5_98_27_1e_f1_11_41_b8_ae_52_b4_e0_30_5d_bf_d4};
    tbl[1] = '{128'he5_98_27_1e_f1_11_41_b8_ae_52_b4_e0_30_5d_bf_d4, 1'b0,
               128'h30_52_41_1e_e5_5d_b4_b8_f1_98_bf_e0_ae_11_27_d4};
    tbl[2] = '{128'h0f_0e_0d_0c_0b_0a_09_08_07_06_05_04_03_02_01_00, 1'b1,
               128'h0b_06_01_0c_07_02_0d_08_03_0e_09_04_0f_0a_05_00};
    tbl[3] = '{128'h0f_0e_0d_0c_0b_0a_09_08_07_06_05_04_03_02_01_00, 1'b0,
               128'h03_06_09_0c_0f_02_05_08_0b_0e_01_04_07_0a_0d_00};
    tbl[4] = '{128'h000000dd_000000cc_000000bb_000000aa, 1'b1,
               128'h000000dd_000000cc_000000bb_000000aa};
    tbl[5] = '{128'h000000dd_000000cc_000000bb_000000aa, 1'b0,
               128'h000000dd_000000cc_000000bb_000000aa};

    // Reset state, then release between edges.
    repeat (3) @(negedge Clk);
    chk("rst_out_valid", 128'(Out_valid), 128'd0);
    chk("rst_in_ready", 128'(In_ready), 128'd0);
    chk("rst_out_block", Out_block, 128'd0);
    chk("rst_out_encrypt", 128'(Out_encrypt), 128'd0);
    #2 Rst_n = 1'b1;
    @(negedge Clk);
    chk("rel_in_ready", 128'(In_ready), 128'd1);

    // Fixed vectors.
    for (int i = 0; i < 6; i++) begin
      In_block = tbl[i].blk; In_encrypt = tbl[i].enc; In_valid = 1'b1; Out_ready = 1'b1;
      @(negedge Clk);
      In_valid = 1'b0;
      chk($sformatf("tbl%0d_valid", i), 128'(Out_valid), 128'd1);
      chk($sformatf("tbl%0d_block", i), Out_block, tbl[i].exp);
      chk($sformatf("tbl%0d_enc", i), 128'(Out_encrypt), 128'(tbl[i].enc));
      @(negedge Clk);
      chk($sformatf("tbl%0d_drain", i), 128'(Out_valid), 128'd0);
    end

    // Backpressure: A and B fill the buffer, C is ignored.
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    Out_ready = 1'b0; In_valid = 1'b1; In_block = a; In_encrypt = 1'b1;
    @(negedge Clk);
    chk("bp_ready_after_a", 128'(In_ready), 128'd1);
    In_block = b; In_encrypt = 1'b0;
    @(negedge Clk);
    chk("bp_full", 128'(In_ready), 128'd0);
    In_block = c; In_encrypt = 1'b1;
    @(negedge Clk);
    In_valid = 1'b0;
    held = Out_block;
    chk("bp_head_a", Out_block, ref_perm(a, 1'b1));
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("bp_stable", Out_block, held);
      chk("bp_stable_enc", 128'(Out_encrypt), 128'd1);
    end
    Out_ready = 1'b1;
    @(negedge Clk);
    chk("bp_head_b", Out_block, ref_perm(b, 1'b0));
    chk("bp_b_enc", 128'(Out_encrypt), 128'd0);
    chk("bp_ready_back", 128'(In_ready), 128'd1);
    @(negedge Clk);
    chk("bp_no_c", 128'(Out_valid), 128'd0);

    // Streaming with alternating direction.
    for (int i = 0; i < 17; i++) begin
      if (i > 0) begin
        chk($sformatf("str%0d_valid", i - 1), 128'(Out_valid), 128'd1);
        chk($sformatf("str%0d_block", i - 1), Out_block, ref_perm(sblk[i-1], 1'((i - 1) % 2)));
        chk($sformatf("str%0d_enc", i - 1), 128'(Out_encrypt), 128'((i - 1) % 2));
      end
      if (i < 16) begin
        sblk[i] = {$urandom, $urandom, $urandom, $urandom};
        In_block = sblk[i]; In_encrypt = 1'(i % 2); In_valid = 1'b1;
      end else begin
        In_valid = 1'b0;
      end
      @(negedge Clk);
    end

    // Asynchronous reset while full.
    Out_ready = 1'b0; In_valid = 1'b1; In_block = a; In_encrypt = 1'b1;
    repeat (2) @(negedge Clk);
    In_valid = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(Out_valid), 128'd0);
    chk("arst_out_block", Out_block, 128'd0);
    chk("arst_in_ready", 128'(In_ready), 128'd0);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    @(negedge Clk);
    chk("arst_rel_ready", 128'(In_ready), 128'd1);
    Out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("arst_no_stale", 128'(Out_valid), 128'd0);
    end

`ifdef AES_SHIFT_ROWS_STAGE_COUNT_EN
    In_valid = 1'b1;
    repeat (5) @(negedge Clk);
    In_valid = 1'b0;
    @(negedge Clk);
    chk("count_five", 128'(Block_count), 128'd5);
    force dut.block_count_q = 32'hFFFF_FFFF;
    @(negedge Clk);
    release dut.block_count_q;
    m_pops = 32'hFFFF_FFFF;
    In_valid = 1'b1;
    @(negedge Clk);
    In_valid = 1'b0;
    @(negedge Clk);
    chk("count_wrap", 128'(Block_count), 128'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      In_valid   = 1'($urandom_range(0, 1));
      Out_ready  = ($urandom_range(0, 3) != 0);
      In_block   = {$urandom, $urandom, $urandom, $urandom};
      In_encrypt = 1'($urandom_range(0, 1));
      @(negedge Clk);
    end
    In_valid = 1'b0; Out_ready = 1'b1;
    repeat (3) @(negedge Clk);

    // Encrypt then decrypt is identity.
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      In_block = x; In_encrypt = 1'b1; In_valid = 1'b1;
      @(negedge Clk);
      y = Out_block;
      In_block = y; In_encrypt = 1'b0;
      @(negedge Clk);
      In_valid = 1'b0;
      chk("roundtrip", Out_block, x);
      @(negedge Clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_shift_rows_stage.md
Name: aes_shift_rows_stage

Overview:
Registered ShiftRows / InvShiftRows pipeline stage. It sits directly downstream of the SubBytes block in the AES round datapath and consumes its 128-bit output together with the per-block encrypt/decrypt direction. It presents the permuted state to the MixColumns/AddRoundKey stage over a valid/ready handshake. A 2-entry skid buffer decouples upstream from downstream stalls without combinational ready paths.

Parameters:
BLOCK_SIZE, `AES_BLOCK_SIZE (128), state width in bits; only 128 is supported.
DEPTH, 2, skid buffer entries; fixed at 2 and not user-tunable.

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  reset, asynchronous, active-low
In_valid  input  1  upstream block valid
In_ready  output  1  stage can accept a block
In_encrypt  input  1  1 = ShiftRows, 0 = InvShiftRows; qualified by In_valid
In_block  input  BLOCK_SIZE  SubBytes output state
Out_valid  output  1  output block valid
Out_ready  input  1  downstream accepts
Out_encrypt  output  1  direction travelling with the block
Out_block  output  BLOCK_SIZE  permuted state

Behaviour:
- State layout: byte k = bits [8k+7:8k]; k = r + 4c (row r, column c, each 0..3), column-major per FIPS-197.
- Encrypt permutation: out[r+4c] = in[r + 4*((c+r) mod 4)].
- Decrypt permutation: out[r+4c] = in[r + 4*((c-r) mod 4)].
- Row 0 is never moved.
- The permutation is applied on the input side, before storage. Stored entries hold final data.
- Transfers: input transfer = In_valid & In_ready; output transfer = Out_valid & Out_ready.
- Occupancy counter cnt ranges 0..2.
- Entry order: head = entry 0, presented on Out_*. Entry 1 is the skid slot.
- In_ready = (cnt != 2), registered; no combinational path from Out_ready.
- Out_valid = (cnt != 0), registered.
- Latency: a block accepted in cycle N is visible on Out_* in cycle N+1 (1-cycle latency). There is no same-cycle pass-through.
- Simultaneous push and pop at cnt=1: the head is retired, the new block becomes the head, and cnt stays 1. Throughput is 1 block/cycle sustained.
- Push at cnt=0 or cnt=1 without a pop: the block is written to the first free entry in order.
- Pop at cnt=2: entry 1 moves to entry 0.
- FIFO order is strictly preserved. Out_encrypt always matches the In_encrypt sampled with that block.
- Stability: while Out_valid=1 and Out_ready=0, Out_block and Out_encrypt hold constant.
- Inputs while In_ready=0 are ignored, regardless of In_valid.
- When Out_valid=0, Out_block/Out_encrypt are don't-care but deterministic: they hold the last value.
- Reset values: Out_valid=0, Out_block=0, Out_encrypt=0, cnt=0, storage cleared.
- In_ready=0 while Rst_n is asserted, and goes to 1 on the first clock after deassertion.
- Reset mid-operation: all buffered blocks are discarded immediately (asynchronous). No partial transfer completes.

Optional Feature:
- Macro: AES_SHIFT_ROWS_STAGE_COUNT_EN.
- When defined: adds output port Block_count, 32 bits, reset 0. It increments by 1 on each output transfer and wraps from 0xFFFFFFFF to 0.
- When undefined: the port and counter are absent. The remaining behaviour is identical.

Test Plan:
- Encrypt vector: In_block bytes 0..15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30, In_encrypt=1, Out_ready=1 -> next cycle Out_valid=1, Out_block bytes = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, Out_encrypt=1.
- Decrypt inverse: feed the permuted vector above with In_encrypt=0 -> Out_block equals the original d4 27 11 ae ... 52 30. A random-block round trip encrypt->decrypt is identity over 1000 blocks.
- Backpressure: Out_ready=0 and push blocks A, B -> cnt=2, In_ready=0 the following cycle, and a third block C is ignored. Then raise Out_ready -> A then B appear on consecutive cycles, Out_block is stable during the stall, and In_ready returns to 1 after the first pop.
- Streaming: In_valid=1 and Out_ready=1 for 16 cycles with alternating In_encrypt -> 16 outputs on 16 consecutive cycles after 1-cycle latency, with correct per-block direction and order.
- Async reset with cnt=2: pulse Rst_n low mid-cycle -> Out_valid=0 and Out_block=0 immediately; after release In_ready=1 and no stale block emerges.
- With AES_SHIFT_ROWS_STAGE_COUNT_EN defined: 5 output transfers -> Block_count=5; force the counter to 0xFFFFFFFF plus one transfer -> 0.
